pwm_capture: RTL

Measures an incoming PWM waveform and reports its frequency in Hz and its duty cycle in 1/1024 steps, the inverse of the PWM generator. The block sits on the sensing side of the theremin datapath. It runs on the 100 MHz system clock and accepts an asynchronous pulse-train input. Results come out in the same units the generator consumes: a 32-bit Hz value and a 10-bit duty.

---
 rtl/pwm_pkg.sv | 26 ++
 rtl/pwm_div.sv | 58 +++++
 rtl/pwm_capture.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared types, widths and helpers for the pwm_capture block.
package pwm_pkg;

  typedef enum logic [1:0] {
    SYNC    = 2'd0,
    MEASURE = 2'd1,
    DIV_F   = 2'd2,
    DIV_D   = 2'd3
  } state_t;

  localparam int DUTY_W  = 10;
  localparam int CNT_W   = 32;
  localparam int DIV_N_W = CNT_W + DUTY_W;
  localparam int ITER_W  = $clog2(DIV_N_W + 1);

  localparam logic [DUTY_W-1:0] DUTY_MAX = {DUTY_W{1'b1}};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [DUTY_W-1:0] sat_duty(input logic [DIV_N_W-1:0] q);
    return (q > DIV_N_W'(DUTY_MAX)) ? DUTY_MAX : q[DUTY_W-1:0];
  endfunction

endpackage

// File: rtl/pwm_div.sv
// Sequential radix-2 restoring divider: one load cycle, then one quotient bit per cycle.
module pwm_div
  import pwm_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [DIV_N_W-1:0] dividend,
  input  logic [CNT_W-1:0]   divisor,
  output logic [DIV_N_W-1:0] quotient,
  output logic               done
);

  logic [CNT_W-1:0]  rem;
  logic [CNT_W-1:0]  dvs;
  logic [ITER_W-1:0] cnt;
  logic              busy;
  logic [CNT_W:0]    trial;
  logic              ge;
  logic [CNT_W-1:0]  rem_next;

  // The 33-bit trial remainder is below 2*divisor, so the low 32 bits of the
  // subtraction are exact whenever the trial is at least the divisor.
  always_comb begin
    trial    = {rem, quotient[DIV_N_W-1]};
    ge       = trial[CNT_W] | (trial[CNT_W-1:0] >= dvs);
    rem_next = ge ? (trial[CNT_W-1:0] - dvs) : trial[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem      <= '0;
      dvs      <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      quotient <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem      <= '0;
        dvs      <= divisor;
        quotient <= dividend;
        cnt      <= ITER_W'(DIV_N_W);
        busy     <= 1'b1;
      end else if (busy) begin
        rem      <= rem_next;
        quotient <= {quotient[DIV_N_W-2:0], ge};
        cnt      <= cnt - ITER_W'(1);
        if (cnt == ITER_W'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pwm_capture.sv
// Measures PWM frequency (Hz) and duty (1/1024) from an asynchronous pulse train.
// Define PWM_CAPTURE_GLITCH_FILTER_EN to add a 3-sample stability filter after the synchronizer.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 100_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 100_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pwm_in,
  output logic [CNT_W-1:0]  freq,
  output logic [DUTY_W-1:0] duty,
  output logic              valid,
  output logic              overrun
);

  logic [1:0]         sync_q;
  logic               sig;
  logic               sig_d;
  logic               rise;
  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   period_cnt;
  logic [CNT_W-1:0]   high_cnt;
  logic [CNT_W-1:0]   period_snap;
  logic [CNT_W-1:0]   high_snap;
  logic [CNT_W-1:0]   freq_hold;
  logic               tmo_hit;
  logic               timeout;
  logic               accept;
  logic               drop;
  logic               clear;
  logic               start_duty;
  logic               publish;
  logic               start_req;
  logic               div_start;
  logic               div_done;
  logic [DIV_N_W-1:0] div_dividend;
  logic [DIV_N_W-1:0] div_quotient;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_q <= '0;
    else        sync_q <= {sync_q[0], pwm_in};
  end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  logic [1:0] hist;
  logic       filt;

  // The filtered level only follows the input after three equal samples.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist <= '0;
      filt <= 1'b0;
    end else begin
      hist <= {hist[0], sync_q[1]};
      if (sync_q[1] == hist[0] && sync_q[1] == hist[1]) filt <= sync_q[1];
    end
  end

  assign sig = filt;
`else
  assign sig = sync_q[1];
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sig_d <= 1'b0;
    else        sig_d <= sig;
  end

  assign rise    = sig & ~sig_d;
  assign tmo_hit = (period_cnt >= CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= SYNC;
    else        state <= state_next;
  end

  // A timeout coinciding with an edge consumes that edge as the exit from SYNC.
  always_comb begin
    state_next = state;
    timeout    = 1'b0;
    accept     = 1'b0;
    drop       = 1'b0;
    clear      = 1'b0;
    start_duty = 1'b0;
    publish    = 1'b0;
    case (state)
      SYNC, MEASURE: begin
        if (tmo_hit) begin
          timeout    = 1'b1;
          clear      = 1'b1;
          state_next = rise ? MEASURE : SYNC;
        end else if (rise) begin
          clear      = 1'b1;
          accept     = (state == MEASURE);
          state_next = (state == MEASURE) ? DIV_F : MEASURE;
        end
      end
      DIV_F: begin
        if (rise) begin
          drop  = 1'b1;
          clear = 1'b1;
        end
        if (div_done) begin
          start_duty = 1'b1;
          state_next = DIV_D;
        end
      end
      DIV_D: begin
        if (rise) begin
          drop  = 1'b1;
          clear = 1'b1;
        end
        if (div_done) begin
          publish    = 1'b1;
          state_next = MEASURE;
        end
      end
      default: state_next = SYNC;
    endcase
  end

  // The counters restart to zero on an edge, so the snapshot adds back the edge cycle.
  // The high count samples the delayed level so both edges see the same latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      period_cnt  <= '0;
      high_cnt    <= '0;
      period_snap <= '0;
      high_snap   <= '0;
      start_req   <= 1'b0;
      freq_hold   <= '0;
    end else begin
      start_req <= accept;
      if (clear) begin
        period_cnt <= '0;
        high_cnt   <= '0;
      end else begin
        period_cnt <= sat_inc(period_cnt);
        if (sig_d) high_cnt <= sat_inc(high_cnt);
      end
      if (accept) begin
        period_snap <= sat_inc(period_cnt);
        high_snap   <= high_cnt;
      end
      if (start_duty) freq_hold <= div_quotient[CNT_W-1:0];
    end
  end

  assign div_start    = start_req | start_duty;
  assign div_dividend = start_duty ? {high_snap, {DUTY_W{1'b0}}} : DIV_N_W'(CLK_HZ);

  pwm_div u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (period_snap),
    .quotient (div_quotient),
    .done     (div_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      freq    <= '0;
      duty    <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      valid   <= timeout | publish;
      overrun <= drop;
      if (timeout) begin
        freq <= '0;
        duty <= sig ? DUTY_MAX : '0;
      end else if (publish) begin
        freq <= freq_hold;
        duty <= sat_duty(div_quotient);
      end
    end
  end

endmodule
